// File: rtl/demux_buf_if.sv
// Handshake bundle between a single producer and the two-channel demux buffer.
// The producer side uses the master modport; the demux itself uses slave.
interface demux_buf_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
);
   logic [WIDTH-1:0]         iZ;
   logic                     S0;
   logic                     iValid;
   logic                     oReady;
   logic [WIDTH-1:0]         oC0;
   logic [WIDTH-1:0]         oC1;
   logic                     oValid0;
   logic                     oValid1;
   logic                     iReady0;
   logic                     iReady1;
   logic [$clog2(DEPTH):0]   oCount0;
   logic [$clog2(DEPTH):0]   oCount1;

   modport master (
      output iZ, S0, iValid, iReady0, iReady1,
      input  oReady, oC0, oC1, oValid0, oValid1, oCount0, oCount1
   );

   modport slave (
      input  iZ, S0, iValid, iReady0, iReady1,
      output oReady, oC0, oC1, oValid0, oValid1, oCount0, oCount1
   );
endinterface

// File: rtl/demux_buf.sv
// Registered 1-to-2 demultiplexer: one input stream steered by S0 into two
// independent FIFOs, each with its own valid/ready drain handshake.
module demux_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst,
   demux_buf_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem   [2][DEPTH];
   logic [PW-1:0]    r_wrPtr [2];
   logic [PW-1:0]    r_rdPtr [2];
   logic [CW-1:0]    r_count [2];

   logic [1:0] w_full;
   logic [1:0] w_push;
   logic [1:0] w_pop;
   logic [1:0] w_sinkReady;
   logic       w_accept;

   assign w_sinkReady = {bus.iReady1, bus.iReady0};

   // Full comes from the count so a same-cycle pop can never open room for a push.
   for (genvar k = 0; k < 2; k++) begin : g_flags
      assign w_full[k] = (r_count[k] == CW'(DEPTH));
      assign w_pop[k]  = (r_count[k] != '0) && w_sinkReady[k];
   end

   assign bus.oReady = ~w_full[bus.S0];
   assign w_accept   = bus.iValid && bus.oReady;
   assign w_push     = {w_accept && bus.S0, w_accept && !bus.S0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            r_wrPtr[k] <= '0;
            r_rdPtr[k] <= '0;
            r_count[k] <= '0;
            for (int d = 0; d < DEPTH; d++) begin
               r_mem[k][d] <= '0;
            end
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (w_push[k]) begin
               r_mem[k][r_wrPtr[k]] <= bus.iZ;
               r_wrPtr[k]           <= r_wrPtr[k] + PW'(1);
            end
            if (w_pop[k]) begin
               r_rdPtr[k] <= r_rdPtr[k] + PW'(1);
            end
            case ({w_push[k], w_pop[k]})
               2'b10:   r_count[k] <= r_count[k] + CW'(1);
               2'b01:   r_count[k] <= r_count[k] - CW'(1);
               default: r_count[k] <= r_count[k];
            endcase
         end
      end
   end

   assign bus.oC0     = r_mem[0][r_rdPtr[0]];
   assign bus.oC1     = r_mem[1][r_rdPtr[1]];
   assign bus.oValid0 = (r_count[0] != '0);
   assign bus.oValid1 = (r_count[1] != '0);
   assign bus.oCount0 = r_count[0];
   assign bus.oCount1 = r_count[1];
endmodule

// File: tb/tb_demux_buf.sv
// Directed scoreboard bench for demux_buf: words are queued per channel when
// driven and compared against the channel head every cycle.
module tb_demux_buf;
   localparam int WIDTH = 32;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int testsRun  = 0;
   int failCount = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   demux_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      assert (got === exp)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drives one cycle, checks outputs mid-cycle against the queues, then
   // updates the queues with what the coming edge should do.
   task automatic applyStimulus(input logic v, input logic s, input logic [31:0] z,
                                input logic r0, input logic r1);
      logic acc, p0, p1;
      int   selCount;
      bus.iValid  = v;
      bus.S0      = s;
      bus.iZ      = z;
      bus.iReady0 = r0;
      bus.iReady1 = r1;
      @(negedge clk);
      selCount = s ? q1.size() : q0.size();
      checkOutput("oReady",  32'(bus.oReady),  32'(selCount < DEPTH));
      checkOutput("oValid0", 32'(bus.oValid0), 32'(q0.size() != 0));
      checkOutput("oValid1", 32'(bus.oValid1), 32'(q1.size() != 0));
      checkOutput("oCount0", 32'(bus.oCount0), 32'(q0.size()));
      checkOutput("oCount1", 32'(bus.oCount1), 32'(q1.size()));
      if (q0.size() != 0) checkOutput("oC0", bus.oC0, q0[0]);
      if (q1.size() != 0) checkOutput("oC1", bus.oC1, q1[0]);
      acc = v && (selCount < DEPTH);
      p0  = r0 && (q0.size() != 0);
      p1  = r1 && (q1.size() != 0);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
         if (s) q1.push_back(z);
         else   q0.push_back(z);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.iValid  = 1'b0;
      bus.S0      = 1'b0;
      bus.iZ      = '0;
      bus.iReady0 = 1'b0;
      bus.iReady1 = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_oValid0", 32'(bus.oValid0), 32'd0);
      checkOutput("rst_oValid1", 32'(bus.oValid1), 32'd0);
      checkOutput("rst_oCount0", 32'(bus.oCount0), 32'd0);
      checkOutput("rst_oCount1", 32'(bus.oCount1), 32'd0);
      checkOutput("rst_oReady",  32'(bus.oReady),  32'd1);
      checkOutput("rst_oC0",     bus.oC0,          32'd0);
      checkOutput("rst_oC1",     bus.oC1,          32'd0);
      #3 rst = 1'b0;

      // First push lands on the first edge after release
      applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
      checkOutput("push_oValid0", 32'(bus.oValid0), 32'd1);
      checkOutput("push_oC0",     bus.oC0,          32'hDEADBEEF);
      checkOutput("push_oCount0", 32'(bus.oCount0), 32'd1);
      checkOutput("push_oValid1", 32'(bus.oValid1), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Fill channel 0 and stall a third word
      applyStimulus(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h2, 1'b0, 1'b0);
      checkOutput("full_oCount0", 32'(bus.oCount0), 32'd2);
      checkOutput("full_oReady",  32'(bus.oReady),  32'd0);
      applyStimulus(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
      checkOutput("stall_oCount0", 32'(bus.oCount0), 32'd2);
      checkOutput("stall_oC0",     bus.oC0,          32'h1);
      applyStimulus(1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
      checkOutput("redirect_oC1",     bus.oC1,          32'h3);
      checkOutput("redirect_oCount1", 32'(bus.oCount1), 32'd1);

      // Full channel: pop and push in the same cycle, only the pop happens
      applyStimulus(1'b1, 1'b0, 32'h3, 1'b1, 1'b0);
      checkOutput("popfull_oCount0", 32'(bus.oCount0), 32'd1);
      checkOutput("popfull_oC0",     bus.oC0,          32'h2);
      applyStimulus(1'b1, 1'b0, 32'h3, 1'b0, 1'b0);
      checkOutput("retry_oCount0", 32'(bus.oCount0), 32'd2);
      repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("drain_oCount0", 32'(bus.oCount0), 32'd0);
      checkOutput("drain_oCount1", 32'(bus.oCount1), 32'd0);

      // Alternating stream with both sinks ready
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'(i & 1), 32'h10 + 32'(i), 1'b1, 1'b1);
         checkOutput("stream_oReady", 32'(bus.oReady), 32'd1);
      end
      repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("stream_q0_empty", 32'(q0.size()), 32'(bus.oCount0));

      // Asynchronous reset with both channels full
      applyStimulus(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hB0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'hB1, 1'b0, 1'b0);
      bus.iValid = 1'b0;
      checkOutput("prerst_oCount0", 32'(bus.oCount0), 32'd2);
      checkOutput("prerst_oCount1", 32'(bus.oCount1), 32'd2);
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_oValid0", 32'(bus.oValid0), 32'd0);
      checkOutput("midrst_oValid1", 32'(bus.oValid1), 32'd0);
      checkOutput("midrst_oCount0", 32'(bus.oCount0), 32'd0);
      checkOutput("midrst_oCount1", 32'(bus.oCount1), 32'd0);
      checkOutput("midrst_oReady",  32'(bus.oReady),  32'd1);
      q0.delete();
      q1.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      checkOutput("postrst_oValid0", 32'(bus.oValid0), 32'd0);
      checkOutput("postrst_oValid1", 32'(bus.oValid1), 32'd0);

      // Sink ready on an empty channel is ignored
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("spur_oCount1", 32'(bus.oCount1), 32'd0);
      checkOutput("spur_oValid1", 32'(bus.oValid1), 32'd0);
      applyStimulus(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
      checkOutput("spur_after_oC1",     bus.oC1,          32'h55);
      checkOutput("spur_after_oCount1", 32'(bus.oCount1), 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule
